// File: rtl/rv32_muldiv_pkg.sv
// rv32_muldiv_pkg: shared types, constants and op predicates for the RV32M mul/div unit
package rv32_muldiv_pkg;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} muldiv_op_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_t;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction
  function automatic logic is_signed_a(input muldiv_op_t op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction
  function automatic logic is_signed_b(input muldiv_op_t op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction
endpackage

// File: rtl/rv32_muldiv_signfix.sv
// rv32_muldiv_signfix: conditional two's-complement negate
module rv32_muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/rv32_ex_muldiv.sv
// rv32_ex_muldiv: iterative radix-2 RV32M multiply/divide unit for the Execute stage
module rv32_ex_muldiv
  import rv32_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int ITER = XLEN;
  localparam int CW = $clog2(ITER);
  muldiv_state_t state;
  muldiv_op_t op_in, op_q;
  logic sa, sb, sa_q, sb_q, ge, div0, ovf, spec_hit;
  logic [31:0] mag_a, mag_b, mcand, diff, div_sel, div_fix, spec_res, calc_res;
  logic [32:0] mul_sum, rem_sh;
  logic [63:0] acc, acc_nx, prod;
  logic [CW-1:0] cnt;
  assign op_in = muldiv_op_t'(op);
  assign sa = is_signed_a(op_in) & rs1_data[31];
  assign sb = is_signed_b(op_in) & rs2_data[31];
  rv32_muldiv_signfix #(.W(32)) u_mag_a (.a(rs1_data), .neg(sa), .y(mag_a));
  rv32_muldiv_signfix #(.W(32)) u_mag_b (.a(rs2_data), .neg(sb), .y(mag_b));
  assign div0 = rs2_data == '0;
  assign ovf = (op_in inside {DIV, REM}) & (rs1_data == INT_MIN) & (rs2_data == '1);
  assign spec_hit = is_div(op_in) & (div0 | ovf);
  assign spec_res = div0 ? (op_in[1] ? rs1_data : DIV0_QUOT) : (op_in[1] ? '0 : INT_MIN);
  // Multiply keeps {product_hi, multiplier}; divide keeps {remainder, quotient}.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
  assign rem_sh = acc[63:31];
  assign ge = rem_sh >= {1'b0, mcand};
  assign diff = rem_sh[31:0] - mcand;
  assign acc_nx = is_div(op_q) ? (ge ? {diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0})
                               : {mul_sum, acc[31:1]};
  rv32_muldiv_signfix #(.W(64)) u_prod (.a(acc_nx), .neg(sa_q ^ sb_q), .y(prod));
  assign div_sel = op_q[1] ? acc_nx[63:32] : acc_nx[31:0];
  rv32_muldiv_signfix #(.W(32)) u_div (.a(div_sel), .neg(op_q[1] ? sa_q : sa_q ^ sb_q), .y(div_fix));
  assign calc_res = is_div(op_q) ? div_fix : (op_q == MUL ? prod[31:0] : prod[63:32]);
  assign busy = (state == IDLE & start & ~flush) | (state == CALC);
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      result <= '0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      op_q <= MUL;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q <= op_in;
          sa_q <= sa;
          sb_q <= sb;
          cnt <= '0;
          if (spec_hit) begin
            result <= spec_res;
            state <= DONE;
          end else begin
            acc <= {32'd0, is_div(op_in) ? mag_a : mag_b};
            mcand <= is_div(op_in) ? mag_b : mag_a;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            result <= calc_res;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_ex_muldiv.sv
// tb_rv32_ex_muldiv: directed self-checking bench for rv32_ex_muldiv
module tb_rv32_ex_muldiv;
  logic clk = 1'b0;
  logic rst, flush, start, busy, done;
  logic [2:0] op;
  logic [31:0] rs1_data, rs2_data, result;
  int total = 0;
  int bad = 0;
  rv32_ex_muldiv dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input int lat);
    int n;
    logic bz_ok;
    op = o;
    rs1_data = x;
    rs2_data = y;
    start = 1'b1;
    #1;
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    n = 0;
    bz_ok = 1'b1;
    do begin
      tick;
      n++;
      start = 1'b0;
      if (!done && !busy) bz_ok = 1'b0;
    end while (!done && n < 100);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, result, er);
    chk({tag, "_busy_calc"}, {31'd0, bz_ok}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    tick;
    chk({tag, "_done_once"}, {31'd0, done}, 32'd0);
  endtask
  task automatic abort_test(input string tag, input logic use_rst, input logic [31:0] er);
    int d;
    op = 3'd5;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    tick;
    rst = 1'b0;
    flush = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    d = 0;
    repeat (40) begin
      tick;
      if (done) d++;
    end
    chk({tag, "_no_done"}, d, 0);
    chk({tag, "_res"}, result, er);
  endtask
  initial begin
    int n, d, first;
    rst = 1'b1;
    flush = 1'b0;
    start = 1'b0;
    op = '0;
    rs1_data = '0;
    rs2_data = '0;
    repeat (2) tick;
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    run("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    abort_test("flush", 1'b0, 32'h8000_0000);
    abort_test("reset", 1'b1, 32'd0);
    op = 3'd0;
    rs1_data = 32'd9;
    rs2_data = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    #1;
    chk("sf_busy", {31'd0, busy}, 32'd0);
    tick;
    start = 1'b0;
    flush = 1'b0;
    chk("sf_not_acc_busy", {31'd0, busy}, 32'd0);
    chk("sf_not_acc_done", {31'd0, done}, 32'd0);
    op = 3'd0;
    rs1_data = 32'd3;
    rs2_data = 32'd4;
    start = 1'b1;
    n = 0;
    d = 0;
    first = -1;
    while (n < 150 && d < 2) begin
      tick;
      n++;
      if (n == 34) chk("b2b_busy_idle", {31'd0, busy}, 32'd1);
      if (done) begin
        d++;
        if (d == 1) begin
          first = n;
          chk("b2b_res1", result, 32'd12);
          rs1_data = 32'd5;
          rs2_data = 32'd6;
        end else chk("b2b_res2", result, 32'd30);
      end
    end
    start = 1'b0;
    chk("b2b_done_cnt", d, 2);
    chk("b2b_first", first, 33);
    chk("b2b_second", n, 67);
    tick;
    chk("b2b_end_done", {31'd0, done}, 32'd0);
    chk("b2b_end_busy", {31'd0, busy}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
